// File: rtl/exc_ctrl.sv
// exc_ctrl: exception sequencer feeding CP0; orders traps, ERET and masked
// hardware interrupts into single-cycle strobes with stall and PC redirect.
module exc_ctrl #(
    parameter int         IRQ_W        = 6,
    parameter int         SYNC_STAGES  = 2,
    parameter logic [4:0] CODE_INT     = 5'd0,
    parameter logic [4:0] CODE_SYSCALL = 5'd8,
    parameter logic [4:0] CODE_BREAK   = 5'd9,
    parameter logic [4:0] CODE_TEQ     = 5'd13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic             is_syscall,
    input  logic             is_break,
    input  logic             is_teq,
    input  logic             teq_equal,
    input  logic             is_eret,
    input  logic [31:0]      status,
    input  logic [IRQ_W-1:0] irq,
    input  logic [IRQ_W-1:0] irq_ack,
    output logic             exception,
    output logic             eret,
    output logic [4:0]       cause,
    output logic             epc_next,
    output logic             pc_redirect,
    output logic             stall,
    output logic [IRQ_W-1:0] pending
);
    typedef enum logic [1:0] {IDLE, TRAP, REDIR, RET} state_t;
    state_t           state;
    logic [IRQ_W-1:0] sync_q [SYNC_STAGES];
    logic [IRQ_W-1:0] edge_q, rise;
    logic             int_req, sync_trap, status_unused;
    assign rise          = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign int_req       = status[0] & |(pending & status[IRQ_W:1]);
    assign sync_trap     = is_syscall | is_break | (is_teq & teq_equal);
    assign status_unused = ^status[31:IRQ_W+1];
    // Set has priority over ack so a fresh edge is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            edge_q  <= '0;
            pending <= '0;
        end else begin
            sync_q[0] <= irq;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            edge_q  <= sync_q[SYNC_STAGES-1];
            pending <= (pending & ~irq_ack) | rise;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            exception   <= 1'b0;
            eret        <= 1'b0;
            cause       <= '0;
            epc_next    <= 1'b0;
            pc_redirect <= 1'b0;
            stall       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (instr_valid) begin
                    if (sync_trap) begin
                        state     <= TRAP;
                        exception <= 1'b1;
                        stall     <= 1'b1;
                        epc_next  <= 1'b0;
                        cause     <= is_syscall ? CODE_SYSCALL : is_break ? CODE_BREAK : CODE_TEQ;
                    end else if (is_eret) begin
                        state       <= RET;
                        eret        <= 1'b1;
                        pc_redirect <= 1'b1;
                        stall       <= 1'b1;
                    end else if (int_req) begin
                        state     <= TRAP;
                        exception <= 1'b1;
                        stall     <= 1'b1;
                        epc_next  <= 1'b1;
                        cause     <= CODE_INT;
                    end
                end
                TRAP: begin
                    state       <= REDIR;
                    exception   <= 1'b0;
                    pc_redirect <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    eret        <= 1'b0;
                    pc_redirect <= 1'b0;
                    stall       <= 1'b0;
                    cause       <= '0;
                    epc_next    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed and randomized checks of exc_ctrl against a
// cycle-schedule model of the trap/eret/interrupt rules.
module tb_exc_ctrl;
    localparam int W = 6;
    localparam int S = 2;

    typedef struct packed {
        logic       exc;
        logic       er;
        logic [4:0] cause;
        logic       epcn;
        logic       redir;
        logic       stall;
    } out_t;

    logic          clk = 1'b0, rst = 1'b1;
    logic          instr_valid = 0, is_syscall = 0, is_break = 0, is_teq = 0, teq_equal = 0, is_eret = 0;
    logic [31:0]   status = '0;
    logic [W-1:0]  irq = '0, irq_ack = '0;
    logic          exception, eret, epc_next, pc_redirect, stall;
    logic [4:0]    cause;
    logic [W-1:0]  pending;

    int   checks = 0, errors = 0;
    bit   allow_busy = 0;
    out_t q[$];
    out_t cur;
    logic [W-1:0] pend_m;
    logic [W-1:0] hist[$];

    exc_ctrl dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .is_syscall(is_syscall),
        .is_break(is_break), .is_teq(is_teq), .teq_equal(teq_equal), .is_eret(is_eret),
        .status(status), .irq(irq), .irq_ack(irq_ack), .exception(exception), .eret(eret),
        .cause(cause), .epc_next(epc_next), .pc_redirect(pc_redirect), .stall(stall),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        hist.delete();
        cur    = '0;
        pend_m = '0;
        for (int i = 0; i <= S; i++) hist.push_back('0);
    endtask

    // Model: each accepted instruction schedules its whole output sequence.
    initial begin
        logic [W-1:0] rise;
        logic         int_req_m;
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else begin
                int_req_m = status[0] && ((pend_m & status[W:1]) != '0);
                if (cur.stall && instr_valid && !allow_busy) begin
                    checks++;
                    errors++;
                    $display("FAIL protocol: instr_valid while busy at %0t", $time);
                end
                if (!cur.stall && instr_valid) begin
                    if (is_syscall || is_break || (is_teq && teq_equal)) begin
                        q.push_back('{1'b1, 1'b0, is_syscall ? 5'd8 : is_break ? 5'd9 : 5'd13, 1'b0, 1'b0, 1'b1});
                        q.push_back('{1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1});
                    end else if (is_eret)
                        q.push_back('{1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1});
                    else if (int_req_m) begin
                        q.push_back('{1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1});
                        q.push_back('{1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1});
                    end
                end
                cur = (q.size() != 0) ? q.pop_front() : '0;
                hist.push_back(irq);
                rise = hist[1] & ~hist[0];
                void'(hist.pop_front());
                pend_m = (pend_m & ~irq_ack) | rise;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("m_exception", exception, cur.exc);
                chk("m_eret", eret, cur.er);
                chk("m_redirect", pc_redirect, cur.redir);
                chk("m_stall", stall, cur.stall);
                chk("m_pending", pending, pend_m);
                if (cur.exc) begin
                    chk("m_cause", cause, cur.cause);
                    chk("m_epc_next", epc_next, cur.epcn);
                end
            end
        end
    end

    task automatic issue(input logic sys, brk, teq, teqeq, er);
        instr_valid = 1; is_syscall = sys; is_break = brk; is_teq = teq; teq_equal = teqeq; is_eret = er;
        @(negedge clk);
        instr_valid = 0; is_syscall = 0; is_break = 0; is_teq = 0; teq_equal = 0; is_eret = 0;
    endtask

    task automatic pulse_irq0();
        irq[0] = 1'b1;
        @(negedge clk);
        irq[0] = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_outputs", {exception, eret, cause, epc_next, pc_redirect, stall}, '0);
        chk("rst_pending", pending, '0);
        rst = 0;
        @(negedge clk);
        issue(1, 0, 0, 0, 0);
        chk("sys_exc", exception, 1); chk("sys_cause", cause, 8);
        chk("sys_epcn", epc_next, 0); chk("sys_stall", stall, 1);
        @(negedge clk);
        chk("sys_redir", pc_redirect, 1); chk("sys_exc_low", exception, 0); chk("sys_stall2", stall, 1);
        @(negedge clk);
        chk("sys_idle", {stall, pc_redirect}, 0);
        issue(0, 0, 1, 0, 0);
        chk("teq_ne", {exception, stall}, 0);
        issue(0, 0, 1, 1, 0);
        chk("teq_eq_cause", cause, 13); chk("teq_eq_exc", exception, 1);
        repeat (2) @(negedge clk);
        issue(1, 1, 0, 0, 0);
        chk("sysbrk_cause", cause, 8);
        repeat (2) @(negedge clk);
        issue(0, 0, 0, 0, 1);
        chk("eret_strobe", {eret, pc_redirect, exception}, 3'b110);
        @(negedge clk);
        chk("eret_done", {eret, pc_redirect, stall}, 0);
        status = 32'h3;
        pulse_irq0();
        chk("irq_lat1", pending, 0);
        @(negedge clk);
        chk("irq_lat2", pending, 0);
        @(negedge clk);
        chk("irq_lat3", pending, 6'b000001);
        issue(0, 0, 0, 0, 0);
        chk("int_exc", exception, 1); chk("int_cause", cause, 0); chk("int_epcn", epc_next, 1);
        repeat (2) @(negedge clk);
        irq_ack[0] = 1;
        @(negedge clk);
        irq_ack[0] = 0;
        chk("ack_clear", pending, 0);
        status = 32'h2;
        pulse_irq0();
        repeat (2) @(negedge clk);
        chk("ie0_pending", pending, 1);
        issue(0, 0, 0, 0, 0);
        chk("ie0_no_exc", exception, 0);
        pulse_irq0();
        @(negedge clk);
        irq_ack[0] = 1;
        @(negedge clk);
        irq_ack[0] = 0;
        chk("set_wins", pending, 1);
        status = 32'h0;
        issue(0, 1, 0, 0, 0);
        allow_busy = 1;
        instr_valid = 1; is_break = 1;
        @(negedge clk);
        instr_valid = 0; is_break = 0; allow_busy = 0;
        chk("busy_redir", {pc_redirect, exception}, 2'b10);
        @(negedge clk);
        chk("busy_ignored1", {stall, exception}, 0);
        @(negedge clk);
        chk("busy_ignored2", {stall, exception}, 0);
        issue(1, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst = 1;
        #1 chk("midrst_out", {exception, eret, pc_redirect, stall}, 0);
        chk("midrst_pend", pending, 0);
        #1 rst = 0;
        @(negedge clk);
        issue(1, 0, 0, 0, 0);
        chk("post_rst_exc", {exception, cause}, {1'b1, 5'd8});
        repeat (2) @(negedge clk);
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < W; b++) if ($urandom_range(0, 9) == 0) irq[b] = ~irq[b];
            irq_ack = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            if ($urandom_range(0, 19) == 0) status = {25'd0, 6'($urandom), 1'($urandom_range(0, 3) != 0)};
            if (!cur.stall && $urandom_range(0, 2) == 0) begin
                instr_valid = 1;
                is_syscall  = ($urandom_range(0, 9) == 0);
                is_break    = ($urandom_range(0, 9) == 0);
                is_teq      = ($urandom_range(0, 5) == 0);
                teq_equal   = 1'($urandom);
                is_eret     = ($urandom_range(0, 9) == 0);
            end else begin
                instr_valid = 0; is_syscall = 0; is_break = 0; is_teq = 0; teq_equal = 0; is_eret = 0;
            end
            @(negedge clk);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
